mem_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream memory port among `PORTS` upstream requesters, all speaking the pulse-request/ready memory protocol used by `ram`, `spm`, `split` and `combine`. Each requester's single-cycle `re`/`we` pulse is latched, queued, and issued downstream in fair order, with read data returned to the owning port. It generalises the two-way `combine` to N ports and sits between processor-side ports and a memory subsystem (`ram`, `spm`, cache).

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/rr_select.sv | 31 +++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the round-robin memory arbiter: protocol width
// defaults, arbiter FSM encoding and the round-robin index helper.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 64;
    localparam int DEF_WORD_WIDTH = 64;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    // (base + offset) mod ports, for base < ports and offset <= ports
    function automatic int rr_index(input int base, input int offset, input int ports);
        int sum;
        sum = base + offset;
        return (sum >= ports) ? sum - ports : sum;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first asserted request found by
// scanning upward from last+1, wrapping modulo PORTS.
module rr_select
    import mem_arbiter_pkg::*;
#(
    parameter  int PORTS = 4,
    localparam int IDX_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    logic [IDX_W-1:0] sel;

    // Scan from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        sel   = '0;
        for (int k = PORTS; k >= 1; k--) begin
            sel = IDX_W'(rr_index(int'(last), k, PORTS));
            if (req[sel]) begin
                grant = sel;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-port round-robin arbiter for the pulse-request/ready memory protocol:
// latches one request per port and serialises them onto one memory port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS*ADDR_WIDTH-1:0]   port_addr,
    input  logic [PORTS*WORD_WIDTH-1:0]   port_din,
    output logic [PORTS*WORD_WIDTH-1:0]   port_dout,
    input  logic [PORTS-1:0]              port_re,
    input  logic [PORTS-1:0]              port_we,
    output logic [PORTS-1:0]              port_ready,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [WORD_WIDTH-1:0]         mem_din,
    input  logic [WORD_WIDTH-1:0]         mem_dout,
    output logic                          mem_re,
    output logic                          mem_we,
    input  logic                          mem_ready
);

    localparam int IDX_W = $clog2(PORTS);

    arb_state_t       state, state_nxt;
    logic [PORTS-1:0] pend;
    logic [IDX_W-1:0] last, grant, win;
    logic             win_vld, start, done;

    logic                  pend_r [PORTS];
    logic                  we_r   [PORTS];
    logic [ADDR_WIDTH-1:0] addr_r [PORTS];
    logic [WORD_WIDTH-1:0] din_r  [PORTS];
    logic [WORD_WIDTH-1:0] dout_r [PORTS];

    assign start = (state == ARB_IDLE) && win_vld && mem_ready;
    assign done  = (state == ARB_WAIT) && mem_ready;

    rr_select #(.PORTS(PORTS)) u_rr_select (
        .req   (pend),
        .last  (last),
        .grant (win),
        .valid (win_vld)
    );

    // Per-port holding registers; a port is ready exactly when nothing is pending.
    for (genvar i = 0; i < PORTS; i++) begin : g_port
        logic capture, finish;

        assign capture = !pend_r[i] && (port_re[i] || port_we[i]);
        assign finish  = done && (grant == IDX_W'(i));
        assign pend[i]       = pend_r[i];
        assign port_ready[i] = !pend_r[i];
        assign port_dout[i*WORD_WIDTH +: WORD_WIDTH] = dout_r[i];

        always_ff @(posedge clk) begin
            if (rst) begin
                pend_r[i] <= 1'b0;
                we_r[i]   <= 1'b0;
                dout_r[i] <= '0;
            end else begin
                if (capture) begin
                    pend_r[i] <= 1'b1;
                    we_r[i]   <= port_we[i];
                end else if (finish) begin
                    pend_r[i] <= 1'b0;
                end
                if (finish && !we_r[i]) begin
                    dout_r[i] <= mem_dout;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (capture) begin
                addr_r[i] <= port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                din_r[i]  <= port_din[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (start) state_nxt = ARB_ISSUE;
            ARB_ISSUE: state_nxt = ARB_WAIT;
            ARB_WAIT:  if (mem_ready) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    // Downstream pulse is registered at the arbitration edge, so it is high
    // only during ISSUE; address and data hold through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            grant    <= '0;
            last     <= IDX_W'(PORTS - 1);
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (start) begin
                grant    <= win;
                mem_re   <= !we_r[win];
                mem_we   <= we_r[win];
                mem_addr <= addr_r[win];
                mem_din  <= din_r[win];
            end
            if (done) begin
                last <= grant;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: behavioural memory with programmable
// latency, expected downstream transactions and per-port read data queues.
module tb_mem_arbiter;

    localparam int P  = 4;
    localparam int AW = 64;
    localparam int WW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [P*AW-1:0] port_addr;
    logic [P*WW-1:0] port_din;
    logic [P*WW-1:0] port_dout;
    logic [P-1:0]    port_re, port_we, port_ready;
    logic [AW-1:0]   mem_addr;
    logic [WW-1:0]   mem_din;
    logic [WW-1:0]   mem_dout;
    logic            mem_re, mem_we, mem_ready;

    mem_arbiter #(.PORTS(P), .ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .port_addr  (port_addr),
        .port_din   (port_din),
        .port_dout  (port_dout),
        .port_re    (port_re),
        .port_we    (port_we),
        .port_ready (port_ready),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] din;
    } dn_t;

    dn_t           dn_q [$];
    logic [WW-1:0] rd_q [P][$];
    logic [P-1:0]  cur_rd;
    logic [WW-1:0] ref_mem [logic [AW-1:0]];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            ord [P];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: latency 1 keeps ready high, latency L drops it L-1 cycles.
    int            mem_lat;
    int            mcnt;
    logic [AW-1:0] m_pa;
    logic          m_pwe;
    logic [WW-1:0] store [logic [AW-1:0]];

    function automatic logic [WW-1:0] rd_store(input logic [AW-1:0] a);
        return store.exists(a) ? store[a] : '0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mem_ready <= 1'b1;
            mcnt      <= 0;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mem_ready <= 1'b1;
                if (!m_pwe) mem_dout <= rd_store(m_pa);
            end
        end else if (mem_re || mem_we) begin
            if (mem_we) store[mem_addr] = mem_din;
            m_pa  <= mem_addr;
            m_pwe <= mem_we;
            if (mem_lat <= 1) begin
                if (!mem_we) mem_dout <= rd_store(mem_addr);
            end else begin
                mem_ready <= 1'b0;
                mcnt      <= mem_lat - 1;
            end
        end
    end

    // Monitor: downstream pulses against dn_q, read completions against rd_q.
    logic         prev_pulse = 1'b0;
    logic [P-1:0] prev_ready = '1;
    dn_t          mon_e;

    always @(negedge clk) begin
        if (mem_re || mem_we) begin
            chk("pulse_width", 64'(prev_pulse), 64'd0);
            chk("pulse_both", 64'(mem_re & mem_we), 64'd0);
            if (dn_q.size() == 0) begin
                chk("dn_unexpected", 64'(dn_q.size()), 64'd1);
            end else begin
                mon_e = dn_q.pop_front();
                chk("dn_we", 64'(mem_we), 64'(mon_e.we));
                chk("dn_addr", mem_addr, mon_e.addr);
                if (mon_e.we) chk("dn_din", mem_din, mon_e.din);
            end
        end
        prev_pulse = mem_re || mem_we;
        for (int i = 0; i < P; i++) begin
            if (!rst && !prev_ready[i] && port_ready[i] && cur_rd[i]) begin
                cur_rd[i] = 1'b0;
                if (rd_q[i].size() == 0)
                    chk($sformatf("rd_unexpected_p%0d", i), 64'(rd_q[i].size()), 64'd1);
                else
                    chk($sformatf("rd_data_p%0d", i), port_dout[i*WW +: WW], rd_q[i].pop_front());
            end
        end
        prev_ready = port_ready;
    end

    task automatic push_exp(input int p, input logic we, input logic [AW-1:0] a, input logic [WW-1:0] d);
        dn_q.push_back('{we, a, (we ? d : '0)});
        if (we) begin
            ref_mem[a] = d;
        end else begin
            rd_q[p].push_back(ref_mem.exists(a) ? ref_mem[a] : '0);
            cur_rd[p] = 1'b1;
        end
    endtask

    task automatic drive_req(input int p, input logic we, input logic [AW-1:0] a, input logic [WW-1:0] d);
        int n = 0;
        while (!port_ready[p] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk($sformatf("ready_timeout_p%0d", p), 64'(port_ready[p]), 64'd1);
        port_we[p] = we;
        port_re[p] = !we;
        port_addr[p*AW +: AW] = a;
        port_din[p*WW +: WW]  = d;
        @(posedge clk);
        #1;
        port_we[p] = 1'b0;
        port_re[p] = 1'b0;
        push_exp(p, we, a, d);
    endtask

    task automatic wait_done(input int p, output int lat, input logic [P-1:0] must);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && must != '0) chk("others_ready", 64'(port_ready & must), 64'(must));
        end while (!port_ready[p] && lat < 200);
    endtask

    task automatic do_req(input int p, input logic we, input logic [AW-1:0] a, input logic [WW-1:0] d,
                          output int lat);
        drive_req(p, we, a, d);
        wait_done(p, lat, '0);
    endtask

    // All masked ports request in one cycle at addr 16+i with data i;
    // ord[0..cnt-1] is the expected downstream order.
    task automatic drive_set(input logic [P-1:0] mask, input logic we, input int cnt);
        int n = 0;
        while ((port_ready & mask) != mask && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < P; i++) begin
            if (mask[i]) begin
                port_we[i] = we;
                port_re[i] = !we;
                port_addr[i*AW +: AW] = AW'(16 + i);
                port_din[i*WW +: WW]  = WW'(i);
            end
        end
        @(posedge clk);
        #1;
        port_we = '0;
        port_re = '0;
        for (int k = 0; k < cnt; k++) push_exp(ord[k], we, AW'(16 + ord[k]), WW'(ord[k]));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (port_ready != '1 && n < 300);
        if (n >= 300) chk(tag, 64'(port_ready), 64'hf);
    endtask

    task automatic flush_sb();
        dn_q.delete();
        for (int i = 0; i < P; i++) rd_q[i].delete();
        cur_rd = '0;
    endtask

    int           lat, la, lb, n;
    int           t_prev, t_now;

    initial begin
        port_addr = '0;
        port_din  = '0;
        port_re   = '0;
        port_we   = '0;
        mem_dout  = '0;
        mem_lat   = 3;
        cur_rd    = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 64'(port_ready), 64'hf);
        chk("rst_mem_re", 64'(mem_re), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        for (int i = 0; i < P; i++) chk($sformatf("rst_dout_p%0d", i), port_dout[i*WW +: WW], 64'd0);

        // Port 2 write then read through a 3-cycle memory
        drive_req(2, 1'b1, 64'd257, 64'h0123456789abcdef);
        wait_done(2, lat, 4'b1011);
        chk("p2_wr_lat", 64'(lat), 64'd6);
        drive_req(2, 1'b0, 64'd257, 64'd0);
        wait_done(2, lat, 4'b1011);
        chk("p2_rd_lat", 64'(lat), 64'd6);
        chk("p2_rd_data", port_dout[2*WW +: WW], 64'h0123456789abcdef);

        // Round robin continues after port 2: order 3,0,1
        ord = '{3, 0, 1, 0};
        drive_set(4'b1011, 1'b1, 3);
        wait_idle("rot_timeout");

        // Fresh reset, then all four write and read together: order 0..3
        flush_sb();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ord = '{0, 1, 2, 3};
        drive_set(4'hf, 1'b1, 4);
        wait_idle("all_wr_timeout");
        drive_set(4'hf, 1'b0, 4);
        wait_idle("all_rd_timeout");
        for (int i = 0; i < P; i++) chk($sformatf("all_rd_p%0d", i), port_dout[i*WW +: WW], 64'(i));

        // Port 0 keeps re-requesting; port 1's single request must go next
        fork
            begin
                for (int k = 0; k < 3; k++) do_req(0, 1'b1, AW'(40 + k), WW'(100 + k), la);
            end
            begin
                repeat (2) @(negedge clk);
                do_req(1, 1'b1, 64'd50, 64'd77, lb);
            end
        join
        wait_idle("fair_timeout");
        chk("fair_dn_left", 64'(dn_q.size()), 64'd0);

        // Single-cycle memory: 4-cycle latency, one request every 4 cycles
        mem_lat = 1;
        do_req(3, 1'b1, 64'd300, 64'hdeadbeefcafef00d, lat);
        chk("sc_wr_lat", 64'(lat), 64'd4);
        t_prev = cyc;
        for (int k = 0; k < 3; k++) begin
            t_now = cyc;
            do_req(3, 1'b0, 64'd300, 64'd0, lat);
            chk("sc_rd_lat", 64'(lat), 64'd4);
            if (k > 0) chk("sc_spacing", 64'(t_now - t_prev), 64'd4);
            t_prev = t_now;
        end
        chk("sc_rd_data", port_dout[3*WW +: WW], 64'hdeadbeefcafef00d);

        // Reset while WAITing with ports 0..2 pending
        mem_lat = 5;
        ord = '{0, 1, 2, 0};
        drive_set(4'b0111, 1'b0, 3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_re && n < 50);
        chk("mid_pulse_seen", 64'(mem_re), 64'd1);
        @(negedge clk);
        flush_sb();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 64'(port_ready), 64'hf);
        chk("mid_rst_re", 64'(mem_re), 64'd0);
        chk("mid_rst_we", 64'(mem_we), 64'd0);
        chk("mid_rst_addr", mem_addr, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < P; i++) chk($sformatf("mid_dout_p%0d", i), port_dout[i*WW +: WW], 64'd0);
        chk("mid_ready_after", 64'(port_ready), 64'hf);

        chk("dn_q_left", 64'(dn_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
